multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control unit for the 16-bit datapath. It sequences each instruction through fetch, decode, execute, memory and write-back. It drives the PC, IR, ImmGen, ALU, register-file and memory strobes. The opcode comes from IR[15:12], and the immediate path (IR[3:0] → ImmGen → 16-bit) is enabled only in the states that consume it.

## Interface
- No parameters; widths fixed to the 16-bit ISA.
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ir_op  in  4  opcode from IR[15:12], valid from DECODE onward
- alu_zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes the current access this cycle
- pc_we  out  1  PC write enable
- pc_src  out  2  00 = PC+1, 01 = PC+imm, 10 = imm (jump)
- ir_we  out  1  IR load
- imm_en  out  1  ImmGen output valid/selected
- alu_src_imm  out  1  ALU B operand: 1 = ImmGen, 0 = rs2
- alu_op  out  3  000 ADD, 001 SUB, 010 AND, 011 OR
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (only with mem_req)
- reg_we  out  1  register-file write
- wb_sel  out  1  0 = ALU result, 1 = memory data
- halted  out  1  in HALT state

## Operation
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR (R-type)
  - 0100 ADDI, 0101 LW, 0110 SW, 0111 BEQ, 1000 JMP, 1111 HALT
  - All other opcodes execute as a NOP.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; reset state is IDLE.
- IDLE → FETCH unconditionally. All outputs are 0 in IDLE.
- FETCH:
  - mem_req=1.
  - While mem_ready=0: hold in FETCH, ir_we=0, pc_we=0.
  - When mem_ready=1: ir_we=1, pc_we=1, pc_src=00, then → DECODE.
- DECODE: latch ir_op into op_q. Next state:
  - undefined opcode → FETCH
  - HALT → HALT
  - everything else → EXEC
- EXEC:
  - R-type: alu_op from op_q[1:0], alu_src_imm=0 → WB.
  - ADDI/LW/SW: imm_en=1, alu_src_imm=1, alu_op=ADD. ADDI → WB; LW/SW → MEM.
  - BEQ: alu_op=SUB, alu_src_imm=0, imm_en=1, pc_src=01, pc_we=alu_zero → FETCH.
  - JMP: imm_en=1, pc_src=10, pc_we=1 → FETCH.
- MEM:
  - mem_req=1; mem_we=1 for SW only.
  - Hold until mem_ready=1. SW → FETCH; LW → WB.
- WB: reg_we=1 for exactly one cycle; wb_sel=1 for LW, 0 otherwise → FETCH.
- HALT: halted=1, all strobes 0. Exit only via rst.
- All outputs are decoded combinationally from the state register, op_q, alu_zero and mem_ready. Any output not listed for a state is 0.

## Timing
- Latency with zero-wait memory (mem_ready tied 1), in cycles:
  - R-type, ADDI: 4
  - LW: 5
  - SW: 4
  - BEQ, JMP: 3
  - NOP: 2
- Each wait cycle (mem_ready=0) in FETCH or MEM adds exactly 1 cycle.
- mem_req remains asserted and stable until the mem_ready=1 cycle. No request is dropped or duplicated.
- pc_we and reg_we are single-cycle pulses; there are never two pulses per instruction, except in FETCH plus BEQ-taken or JMP.
- Reset mid-operation:
  - state → IDLE immediately and all outputs go to 0 asynchronously, including an in-flight mem_req or reg_we.
  - op_q is cleared to 0.
  - First mem_req appears 1 cycle after rst deasserts.
- mem_ready asserted outside FETCH/MEM is ignored.

## Configuration
- INSTR_COUNT_EN defined:
  - Adds output instr_count [15:0], reset 0.
  - Increments by 1 on the final cycle of each retired instruction: the WB cycle, the completing MEM cycle for SW, EXEC for BEQ/JMP, and DECODE for NOP.
  - HALT does not count.
  - Wraps 0xFFFF → 0x0000.
- INSTR_COUNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset: hold rst 3 cycles then release → all outputs 0 during reset; mem_req=1 on the 2nd edge after release.
- ADD (ir_op=0000), mem_ready=1 → ir_we and pc_we pulse in cycle 1; reg_we=1, wb_sel=0 in cycle 4; back to FETCH in cycle 5.
- LW (0101) with mem_ready low for 2 MEM cycles → mem_req held 3 cycles in MEM with mem_we=0; then WB with reg_we=1, wb_sel=1. Total 7 cycles.
- BEQ (0111):
  - alu_zero=1 → pc_we=1, pc_src=01 in EXEC.
  - alu_zero=0 → pc_we=0; returns to FETCH after 3 cycles either way.
- Assert rst during the MEM stage of an SW → mem_req and mem_we drop in the same cycle; IDLE → FETCH after release. Then HALT (1111) → halted=1 stays high for 20 cycles with no strobes.
- INSTR_COUNT_EN: preload via 65535 NOPs (or force), then retire 1 ADD → instr_count 0xFFFF → 0x0000 on the WB cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Multicycle control unit for the 16-bit datapath. Each instruction goes
// through FETCH -> DECODE -> EXEC -> MEM -> WB. Only the states an opcode
// needs are visited. All strobes are decoded combinationally from the state
// register, the latched opcode (op_q), alu_zero and mem_ready.
//
// Optional feature: define INSTR_COUNT_EN to add a 16-bit retired-instruction
// counter on port instr_count. The counter wraps from 0xFFFF to 0x0000.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   ir_op[3:0]   in   opcode from IR[15:12], valid from DECODE onward
//   alu_zero     in   ALU zero flag, sampled in EXEC (BEQ)
//   mem_ready    in   memory completes the current access this cycle
//   pc_we        out  PC write enable
//   pc_src[1:0]  out  00 = PC+1, 01 = PC+imm, 10 = imm (jump)
//   ir_we        out  IR load
//   imm_en       out  ImmGen output valid/selected
//   alu_src_imm  out  ALU B operand: 1 = ImmGen, 0 = rs2
//   alu_op[2:0]  out  000 ADD, 001 SUB, 010 AND, 011 OR
//   mem_req      out  memory access request
//   mem_we       out  memory write (only with mem_req)
//   reg_we       out  register-file write
//   wb_sel       out  0 = ALU result, 1 = memory data
//   halted       out  in HALT state
//   instr_count  out  retired-instruction count (INSTR_COUNT_EN only)
// -----------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  ir_op,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        ir_we,
    output logic        imm_en,
    output logic        alu_src_imm,
    output logic [2:0]  alu_op,
    output logic        mem_req,
    output logic        mem_we,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        halted
`ifdef INSTR_COUNT_EN
    ,
    output logic [15:0] instr_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_REL = 2'b01;
    localparam logic [1:0] PC_ABS = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // Opcodes 0x9..0xE have no meaning and retire as a NOP straight from DECODE.
    function automatic logic is_defined(input logic [3:0] op);
        return (op <= OP_JMP) || (op == OP_HALT);
    endfunction

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;

    // NOTE: non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // NOTE: every next-state and output gets a default first, so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        pc_we       = 1'b0;
        pc_src      = PC_INC;
        ir_we       = 1'b0;
        imm_en      = 1'b0;
        alu_src_imm = 1'b0;
        alu_op      = ALU_ADD;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        halted      = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end

            S_FETCH: begin
                // The request stays up through wait cycles. IR and PC load only on the completing cycle.
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_src  = PC_INC;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                // op_q is not valid until the next cycle, so the branch uses ir_op directly.
                op_d = ir_op;
                if (!is_defined(ir_op)) begin
                    state_d = S_FETCH;
                end else if (ir_op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                case (op_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        alu_op      = {1'b0, op_q[1:0]};
                        alu_src_imm = 1'b0;
                        state_d     = S_WB;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        imm_en      = 1'b1;
                        alu_src_imm = 1'b1;
                        alu_op      = ALU_ADD;
                        state_d     = (op_q == OP_ADDI) ? S_WB : S_MEM;
                    end
                    OP_BEQ: begin
                        // The ALU compares rs1 and rs2 by subtraction. ImmGen supplies the branch offset.
                        alu_op  = ALU_SUB;
                        imm_en  = 1'b1;
                        pc_src  = PC_REL;
                        pc_we   = alu_zero;
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        imm_en  = 1'b1;
                        pc_src  = PC_ABS;
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        state_d = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OP_SW);
                if (mem_ready) begin
                    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                end
            end

            S_WB: begin
                reg_we  = 1'b1;
                wb_sel  = (op_q == OP_LW);
                state_d = S_FETCH;
            end

            S_HALT: begin
                // Only rst leaves this state.
                halted = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef INSTR_COUNT_EN
    logic [15:0] instr_count_q, instr_count_d;
    logic        retire;

    // retire is high on the last cycle of each completed instruction. HALT never retires.
    always_comb begin
        retire = 1'b0;
        case (state_q)
            S_DECODE: retire = !is_defined(ir_op);
            S_EXEC:   retire = (op_q == OP_BEQ) || (op_q == OP_JMP);
            S_MEM:    retire = (op_q == OP_SW) && mem_ready;
            S_WB:     retire = 1'b1;
            default:  retire = 1'b0;
        endcase
        instr_count_d = instr_count_q + {15'd0, retire};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_count_q <= 16'h0000;
        end else begin
            instr_count_q <= instr_count_d;
        end
    end

    assign instr_count = instr_count_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. A table of single instructions runs with
// zero-wait memory. For each instruction the bench counts cycles and strobe
// pulses and compares them with hand-computed values. Hand-written sequences
// cover reset, memory wait states, reset in the middle of an SW, HALT and
// (with INSTR_COUNT_EN) counter wrap. Outputs are sampled 1 ns after the
// falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ir_op;
    logic        alu_zero;
    logic        mem_ready;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        ir_we;
    logic        imm_en;
    logic        alu_src_imm;
    logic [2:0]  alu_op;
    logic        mem_req;
    logic        mem_we;
    logic        reg_we;
    logic        wb_sel;
    logic        halted;
`ifdef INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk),
        .rst(rst),
        .ir_op(ir_op),
        .alu_zero(alu_zero),
        .mem_ready(mem_ready),
        .pc_we(pc_we),
        .pc_src(pc_src),
        .ir_we(ir_we),
        .imm_en(imm_en),
        .alu_src_imm(alu_src_imm),
        .alu_op(alu_op),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .reg_we(reg_we),
        .wb_sel(wb_sel),
        .halted(halted)
`ifdef INSTR_COUNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

    // All outputs packed as {pc_we, pc_src, ir_we, imm_en, alu_src_imm, alu_op, mem_req, mem_we, reg_we, wb_sel, halted}.
    logic [13:0] outs;
    assign outs = {pc_we, pc_src, ir_we, imm_en, alu_src_imm, alu_op,
                   mem_req, mem_we, reg_we, wb_sel, halted};

    function automatic logic [13:0] o(input logic pcw, input logic [1:0] pcs,
                                      input logic irw, input logic imm,
                                      input logic src, input logic [2:0] aop,
                                      input logic mrq, input logic mwe,
                                      input logic rwe, input logic wbs,
                                      input logic hlt);
        return {pcw, pcs, irw, imm, src, aop, mrq, mwe, rwe, wbs, hlt};
    endfunction

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Set mem_ready for the coming cycle, then compare the packed outputs.
    task automatic step(input logic mr, input logic [13:0] exp, input string name);
        @(negedge clk);
        mem_ready = mr;
        #1;
        check(name, {2'b00, outs}, {2'b00, exp});
    endtask

    typedef struct {
        logic [3:0] op;
        logic       zero;
        int         cycles;
        int         pcw;
        int         rwe;
        int         mrq;
        int         mwe;
        int         imm;
        int         src;
        logic       wbs;
        logic [2:0] aop;
        logic [1:0] pcs;
        string      name;
    } vec_t;

    vec_t vecs[12];

    // Call this when the last sample was a completing FETCH cycle. The task returns at the next FETCH.
    task automatic run_instr(input vec_t v);
        int         cyc = 0, pcw = 0, rwe = 0, mrq = 0, mwe = 0, imm = 0, src = 0, hlt = 0;
        logic       wbs = 1'b0;
        logic [2:0] aop = 3'b000;
        logic [1:0] pcs = 2'b00;
        bit         done = 1'b0;
        ir_op    = v.op;
        alu_zero = v.zero;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
                if (ir_we) begin
                    done = 1'b1;
                    break;
                end
            end
            cyc += 1;
            pcw += int'(pc_we);
            rwe += int'(reg_we);
            mrq += int'(mem_req);
            mwe += int'(mem_we);
            imm += int'(imm_en);
            src += int'(alu_src_imm);
            hlt += int'(halted);
            if (reg_we) wbs = wb_sel;
            aop |= alu_op;
            pcs |= pc_src;
        end
        check({v.name, "_refetch"}, 16'(done), 16'd1);
        check({v.name, "_cycles"}, 16'(cyc), 16'(v.cycles));
        check({v.name, "_pc_we"}, 16'(pcw), 16'(v.pcw));
        check({v.name, "_reg_we"}, 16'(rwe), 16'(v.rwe));
        check({v.name, "_mem_req"}, 16'(mrq), 16'(v.mrq));
        check({v.name, "_mem_we"}, 16'(mwe), 16'(v.mwe));
        check({v.name, "_imm_en"}, 16'(imm), 16'(v.imm));
        check({v.name, "_alu_src_imm"}, 16'(src), 16'(v.src));
        check({v.name, "_wb_sel"}, {15'd0, wbs}, {15'd0, v.wbs});
        check({v.name, "_alu_op"}, {13'd0, aop}, {13'd0, v.aop});
        check({v.name, "_pc_src"}, {14'd0, pcs}, {14'd0, v.pcs});
        check({v.name, "_halted"}, 16'(hlt), 16'd0);
    endtask

    logic [13:0] fetch_out;
    logic [15:0] cnt_before;

    initial begin
        fetch_out  = o(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cnt_before = 16'h0;

        //           op    z     cyc pcw rwe mrq mwe imm src wbs   aop     pcs
        vecs[0]  = '{4'h0, 1'b0, 4,  1,  1,  1,  0,  0,  0,  1'b0, 3'b000, 2'b00, "add"};
        vecs[1]  = '{4'h1, 1'b1, 4,  1,  1,  1,  0,  0,  0,  1'b0, 3'b001, 2'b00, "sub"};
        vecs[2]  = '{4'h2, 1'b0, 4,  1,  1,  1,  0,  0,  0,  1'b0, 3'b010, 2'b00, "and"};
        vecs[3]  = '{4'h3, 1'b0, 4,  1,  1,  1,  0,  0,  0,  1'b0, 3'b011, 2'b00, "or"};
        vecs[4]  = '{4'h4, 1'b0, 4,  1,  1,  1,  0,  1,  1,  1'b0, 3'b000, 2'b00, "addi"};
        vecs[5]  = '{4'h5, 1'b0, 5,  1,  1,  2,  0,  1,  1,  1'b1, 3'b000, 2'b00, "lw"};
        vecs[6]  = '{4'h6, 1'b0, 4,  1,  0,  2,  1,  1,  1,  1'b0, 3'b000, 2'b00, "sw"};
        vecs[7]  = '{4'h7, 1'b1, 3,  2,  0,  1,  0,  1,  0,  1'b0, 3'b001, 2'b01, "beq_taken"};
        vecs[8]  = '{4'h7, 1'b0, 3,  1,  0,  1,  0,  1,  0,  1'b0, 3'b001, 2'b01, "beq_not"};
        vecs[9]  = '{4'h8, 1'b0, 3,  2,  0,  1,  0,  1,  0,  1'b0, 3'b000, 2'b10, "jmp"};
        vecs[10] = '{4'h9, 1'b0, 2,  1,  0,  1,  0,  0,  0,  1'b0, 3'b000, 2'b00, "nop9"};
        vecs[11] = '{4'hE, 1'b1, 2,  1,  0,  1,  0,  0,  0,  1'b0, 3'b000, 2'b00, "nopE"};

        // Reset: hold for 3 cycles with all outputs at 0. FETCH follows one cycle after release.
        rst       = 1'b1;
        ir_op     = 4'h0;
        alu_zero  = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("reset_outs", {2'b00, outs}, 16'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("idle_outs", {2'b00, outs}, 16'h0);
`ifdef INSTR_COUNT_EN
        check("count_reset", instr_count, 16'h0);
`endif
        step(1'b1, fetch_out, "first_fetch");

        // Table: one instruction per record, zero-wait memory.
        for (int k = 0; k < 12; k++) begin
`ifdef INSTR_COUNT_EN
            cnt_before = instr_count;
`endif
            run_instr(vecs[k]);
`ifdef INSTR_COUNT_EN
            check({vecs[k].name, "_count"}, instr_count, cnt_before + 16'd1);
`endif
        end

        // LW with two MEM wait cycles, then one FETCH wait cycle.
        ir_op = 4'h5;
        step(1'b1, 14'h0, "lw_decode");
        step(1'b1, o(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "lw_exec");
        step(1'b0, o(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "lw_mem_wait1");
        step(1'b0, o(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "lw_mem_wait2");
        step(1'b1, o(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "lw_mem_done");
        step(1'b1, o(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0), "lw_wb");
        step(1'b0, o(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), "fetch_wait");
        step(1'b1, fetch_out, "fetch_after_wait");

        // SW interrupted by reset in MEM: mem_req and mem_we drop without a clock edge.
        ir_op = 4'h6;
        step(1'b1, 14'h0, "sw_decode");
        step(1'b1, o(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), "sw_exec");
        step(1'b0, o(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), "sw_mem_wait");
        #2;
        rst = 1'b1;
        #1;
        check("sw_rst_async", {2'b00, outs}, 16'h0);
        @(negedge clk);
        #1;
        check("sw_rst_held", {2'b00, outs}, 16'h0);
        rst = 1'b0;
        #1;
        check("sw_idle_after_rst", {2'b00, outs}, 16'h0);
        step(1'b1, fetch_out, "sw_refetch");

`ifdef INSTR_COUNT_EN
        // Wrap: preload the counter to 0xFFFF and retire one ADD.
        dut.instr_count_q = 16'hFFFF;
        ir_op = 4'h0;
        step(1'b1, 14'h0, "wrap_decode");
        check("wrap_pre", instr_count, 16'hFFFF);
        step(1'b1, 14'h0, "wrap_exec");
        step(1'b1, o(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), "wrap_wb");
        check("wrap_at_wb", instr_count, 16'hFFFF);
        step(1'b1, fetch_out, "wrap_fetch");
        check("wrap_after", instr_count, 16'h0000);
`endif

        // HALT: halted stays high with no strobes, and mem_ready is ignored.
        ir_op = 4'hF;
        step(1'b1, 14'h0, "halt_decode");
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom_range(0, 1)), 14'h0001, "halted");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
